// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler for a 4:1 mux: per-channel holding registers, valid/ready capture and an IDLE/GRANT FSM.
// Build with MUX4_SCHED_PRIO_EN defined for fixed lowest-index priority instead of round-robin.
module mux4_rr_sched #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req_valid,
  input  logic [4*WIDTH-1:0] req_data,
  output logic [3:0]         req_ready,
  output logic [WIDTH-1:0]   A,
  output logic [WIDTH-1:0]   B,
  output logic [WIDTH-1:0]   C,
  output logic [WIDTH-1:0]   D,
  output logic [1:0]         sel,
  output logic               grant_valid,
  input  logic               grant_ready
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [3:0]            full_q, full_d;
  logic [3:0]            seen_q;
  logic [1:0]            sel_q, sel_d;
  logic [1:0]            ptr_q, ptr_d;
  logic [3:0][WIDTH-1:0] hold_q, hold_d;
  logic [3:0]            capture;
  logic [3:0]            eligible;

  assign capture  = req_valid & ~full_q;
  // A word is schedulable only from the cycle after its capture, so capture at edge N grants after edge N+2.
  assign eligible = full_q & seen_q;

`ifdef MUX4_SCHED_PRIO_EN
  function automatic logic [1:0] pick(input logic [3:0] el);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (el[i]) r = 2'(i);
    end
    return r;
  endfunction
`else
  function automatic logic [1:0] pick(input logic [3:0] el, input logic [1:0] base);
    logic [1:0] r;
    logic [1:0] idx;
    r = base;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (el[idx]) r = idx;
    end
    return r;
  endfunction
`endif

  always_comb begin
    full_d  = full_q | capture;
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    for (int i = 0; i < 4; i++) begin
      hold_d[i] = capture[i] ? req_data[i*WIDTH +: WIDTH] : hold_q[i];
    end
    if (state_q == IDLE) begin
      if (|eligible) begin
`ifdef MUX4_SCHED_PRIO_EN
        sel_d = pick(eligible);
`else
        sel_d = pick(eligible, ptr_q);
`endif
        state_d = GRANT;
      end
    end else if (grant_ready) begin
      full_d[sel_q] = 1'b0;
`ifdef MUX4_SCHED_PRIO_EN
      ptr_d = 2'd0;
`else
      ptr_d = sel_q + 2'd1;
`endif
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      full_q  <= '0;
      seen_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      seen_q  <= full_q;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign req_ready   = ~full_q;
  assign A           = hold_q[0];
  assign B           = hold_q[1];
  assign C           = hold_q[2];
  assign D           = hold_q[3];
  assign sel         = sel_q;
  assign grant_valid = (state_q == GRANT);

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Bench for mux4_rr_sched: directed scenarios plus a randomized run against a transaction-level model.
module tb_mux4_rr_sched;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [3:0]     req_valid = '0;
  logic [4*W-1:0] req_data = '0;
  logic           grant_ready = 1'b0;
  logic [3:0]     req_ready;
  logic [W-1:0]   A, B, C, D;
  logic [1:0]     sel;
  logic           grant_valid;
  logic [W-1:0]   mux_out;

  int n_vec = 0;
  int n_err = 0;
  int obs_sel[$];
  int obs_word[$];
  int obs_cyc[$];

  // reference model state
  logic [3:0]   m_full;
  logic [W-1:0] m_val[4];
  int           m_age[4];
  int           m_ptr;
  logic         m_busy;
  int           m_sel;

  mux4_rr_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .A(A), .B(B), .C(C), .D(D), .sel(sel), .grant_valid(grant_valid), .grant_ready(grant_ready)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (sel)
      2'd0:    mux_out = A;
      2'd1:    mux_out = B;
      2'd2:    mux_out = C;
      default: mux_out = D;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] m, input logic [4*W-1:0] d);
    req_valid = m;
    req_data  = d;
    tick();
    req_valid = '0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic collect(input int cycles);
    obs_sel.delete();
    obs_word.delete();
    obs_cyc.delete();
    for (int c = 1; c <= cycles; c++) begin
      tick();
      if (grant_valid === 1'b1 && grant_ready === 1'b1) begin
        obs_sel.push_back(int'(sel));
        obs_word.push_back(int'(mux_out));
        obs_cyc.push_back(c);
      end
    end
  endtask

  function automatic int m_choose(input logic [3:0] el);
`ifdef MUX4_SCHED_PRIO_EN
    for (int i = 0; i < 4; i++) if (el[i]) return i;
`else
    for (int k = 0; k < 4; k++) if (el[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
`endif
    return 0;
  endfunction

  task automatic m_reset();
    m_full = '0;
    for (int i = 0; i < 4; i++) begin
      m_val[i] = '0;
      m_age[i] = 0;
    end
    m_ptr = 0;
    m_busy = 1'b0;
    m_sel = 0;
  endtask

  task automatic test_reset();
    #3;
    n_vec++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL reset_gv: got %b expected 0", grant_valid); end
    n_vec++; if (req_ready !== 4'hF) begin n_err++; $display("FAIL reset_ready: got %b expected 1111", req_ready); end
    n_vec++; if (sel !== 2'd0) begin n_err++; $display("FAIL reset_sel: got %0d expected 0", sel); end
    n_vec++; if ({A, B, C, D} !== '0) begin n_err++; $display("FAIL reset_data: got %h expected 0", {A, B, C, D}); end
    @(posedge clk);
    #1 rst = 1'b0;
    load(4'b0010, 16'h00A0);
    n_vec++; if (req_ready !== 4'b1101) begin n_err++; $display("FAIL cap_ready: got %b expected 1101", req_ready); end
    n_vec++; if (B !== 4'hA) begin n_err++; $display("FAIL cap_B: got %h expected a", B); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (req_ready !== 4'hF) begin n_err++; $display("FAIL async_ready: got %b expected 1111", req_ready); end
    n_vec++; if (B !== 4'h0) begin n_err++; $display("FAIL async_B: got %h expected 0", B); end
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    tick();
    n_vec++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL async_nogrant: got %b expected 0", grant_valid); end
  endtask

  task automatic test_single();
    grant_ready = 1'b1;
    load(4'b0100, 16'h0800);
    n_vec++; if (req_ready !== 4'b1011) begin n_err++; $display("FAIL single_ready0: got %b expected 1011", req_ready); end
    n_vec++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL single_gv0: got %b expected 0", grant_valid); end
    tick();
    n_vec++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL single_gv1: got %b expected 0", grant_valid); end
    tick();
    n_vec++; if (grant_valid !== 1'b1) begin n_err++; $display("FAIL single_gv2: got %b expected 1", grant_valid); end
    n_vec++; if (sel !== 2'd2) begin n_err++; $display("FAIL single_sel: got %0d expected 2", sel); end
    n_vec++; if (C !== 4'd8 || mux_out !== 4'd8) begin n_err++; $display("FAIL single_data: got C=%0d out=%0d expected 8", C, mux_out); end
    n_vec++; if (req_ready !== 4'b1011) begin n_err++; $display("FAIL single_ready2: got %b expected 1011", req_ready); end
    tick();
    n_vec++; if (grant_valid !== 1'b0 || req_ready !== 4'hF) begin n_err++; $display("FAIL single_done: got gv=%b ready=%b expected 0/1111", grant_valid, req_ready); end
    tick();
    n_vec++; if (grant_valid !== 1'b0) begin n_err++; $display("FAIL single_once: got %b expected 0", grant_valid); end
  endtask

  task automatic test_all_four();
    int exp_w[4];
    exp_w = '{4, 5, 8, 15};
    do_reset();
    grant_ready = 1'b1;
    load(4'b1111, 16'hF854);
    collect(12);
    n_vec++; if (obs_sel.size() != 4) begin n_err++; $display("FAIL all4_count: got %0d expected 4", obs_sel.size()); end
    for (int i = 0; i < 4 && i < obs_sel.size(); i++) begin
      n_vec++; if (obs_sel[i] != i) begin n_err++; $display("FAIL all4_sel%0d: got %0d expected %0d", i, obs_sel[i], i); end
      n_vec++; if (obs_word[i] != exp_w[i]) begin n_err++; $display("FAIL all4_word%0d: got %0d expected %0d", i, obs_word[i], exp_w[i]); end
      n_vec++; if (obs_cyc[i] != 2 + 2*i) begin n_err++; $display("FAIL all4_cyc%0d: got %0d expected %0d", i, obs_cyc[i], 2 + 2*i); end
    end
  endtask

  task automatic test_wrap();
    int es[2];
    int ew[2];
    load(4'b1001, 16'h3009);
    collect(8);
    n_vec++; if (obs_sel.size() != 2) begin n_err++; $display("FAIL wrap_count: got %0d expected 2", obs_sel.size()); end
    if (obs_sel.size() == 2) begin
      n_vec++; if (obs_sel[0] != 0 || obs_sel[1] != 3) begin n_err++; $display("FAIL wrap_order: got %0d,%0d expected 0,3", obs_sel[0], obs_sel[1]); end
      n_vec++; if (obs_word[0] != 9 || obs_word[1] != 3) begin n_err++; $display("FAIL wrap_words: got %0d,%0d expected 9,3", obs_word[0], obs_word[1]); end
    end
    load(4'b0010, 16'h0060);
    collect(6);
    n_vec++; if (obs_sel.size() != 1 || obs_sel[0] != 1) begin n_err++; $display("FAIL ptr2_setup: got %0d grants expected 1 of ch1", obs_sel.size()); end
    load(4'b1010, 16'h7020);
    collect(8);
`ifdef MUX4_SCHED_PRIO_EN
    es = '{1, 3};
    ew = '{2, 7};
`else
    es = '{3, 1};
    ew = '{7, 2};
`endif
    n_vec++; if (obs_sel.size() != 2) begin n_err++; $display("FAIL p2_count: got %0d expected 2", obs_sel.size()); end
    if (obs_sel.size() == 2) begin
      n_vec++; if (obs_sel[0] != es[0] || obs_sel[1] != es[1]) begin n_err++; $display("FAIL p2_order: got %0d,%0d expected %0d,%0d", obs_sel[0], obs_sel[1], es[0], es[1]); end
      n_vec++; if (obs_word[0] != ew[0] || obs_word[1] != ew[1]) begin n_err++; $display("FAIL p2_words: got %0d,%0d expected %0d,%0d", obs_word[0], obs_word[1], ew[0], ew[1]); end
    end
  endtask

  task automatic test_backpressure();
    grant_ready = 1'b0;
    load(4'b0001, 16'h000C);
    tick();
    tick();
    n_vec++; if (grant_valid !== 1'b1 || sel !== 2'd0) begin n_err++; $display("FAIL bp_start: got gv=%b sel=%0d expected 1/0", grant_valid, sel); end
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        req_valid = 4'b0100;
        req_data  = 16'h0500;
      end
      tick();
      req_valid = '0;
      n_vec++; if (grant_valid !== 1'b1 || sel !== 2'd0 || mux_out !== 4'd12) begin n_err++; $display("FAIL bp_hold%0d: got gv=%b sel=%0d out=%0d expected 1/0/12", c, grant_valid, sel, mux_out); end
    end
    n_vec++; if (req_ready !== 4'b1010 || C !== 4'd5) begin n_err++; $display("FAIL bp_side: got ready=%b C=%0d expected 1010/5", req_ready, C); end
    grant_ready = 1'b1;
    tick();
    n_vec++; if (grant_valid !== 1'b0 || req_ready !== 4'b1011) begin n_err++; $display("FAIL bp_release: got gv=%b ready=%b expected 0/1011", grant_valid, req_ready); end
    collect(4);
    n_vec++; if (obs_sel.size() != 1 || obs_sel[0] != 2 || obs_word[0] != 5 || obs_cyc[0] != 1) begin n_err++; $display("FAIL bp_next: got %0d grants expected ch2 word 5 at cycle 1", obs_sel.size()); end
  endtask

  task automatic test_reset_mid_grant();
    int g;
    grant_ready = 1'b0;
    load(4'b1000, 16'hB000);
    tick();
    tick();
    n_vec++; if (grant_valid !== 1'b1 || sel !== 2'd3) begin n_err++; $display("FAIL rmg_pre: got gv=%b sel=%0d expected 1/3", grant_valid, sel); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (grant_valid !== 1'b0 || req_ready !== 4'hF) begin n_err++; $display("FAIL rmg_drop: got gv=%b ready=%b expected 0/1111", grant_valid, req_ready); end
    n_vec++; if (D !== 4'd0 || sel !== 2'd0) begin n_err++; $display("FAIL rmg_regs: got D=%0d sel=%0d expected 0/0", D, sel); end
    @(posedge clk);
    #1 rst = 1'b0;
    g = 0;
    repeat (6) begin
      tick();
      if (grant_valid !== 1'b0) g++;
    end
    n_vec++; if (g != 0) begin n_err++; $display("FAIL rmg_idle: got %0d grant cycles expected 0", g); end
    grant_ready = 1'b1;
    load(4'b0010, 16'h0040);
    collect(6);
    n_vec++; if (obs_sel.size() != 1 || obs_sel[0] != 1 || obs_word[0] != 4) begin n_err++; $display("FAIL rmg_after: got %0d grants expected one of ch1 word 4", obs_sel.size()); end
  endtask

  task automatic test_random();
    logic [3:0]   nf, el;
    logic [W-1:0] nv[4];
    int           na[4];
    int           nptr, nsel;
    logic         nbusy;
    do_reset();
    m_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      req_valid   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      req_data    = 16'($urandom);
      grant_ready = ($urandom_range(0, 3) != 0);
      nf = m_full;
      nptr = m_ptr;
      nsel = m_sel;
      nbusy = m_busy;
      for (int i = 0; i < 4; i++) begin
        nv[i] = m_val[i];
        na[i] = (m_full[i] && m_age[i] < 2) ? m_age[i] + 1 : m_age[i];
        el[i] = m_full[i] && (m_age[i] >= 1);
        if (req_valid[i] && !m_full[i]) begin
          nf[i] = 1'b1;
          nv[i] = req_data[i*W +: W];
          na[i] = 0;
        end
      end
      if (m_busy) begin
        if (grant_ready) begin
          nf[m_sel] = 1'b0;
          nbusy = 1'b0;
`ifdef MUX4_SCHED_PRIO_EN
          nptr = 0;
`else
          nptr = (m_sel + 1) % 4;
`endif
        end
      end else if (el != 4'b0000) begin
        nsel = m_choose(el);
        nbusy = 1'b1;
      end
      tick();
      m_full = nf;
      m_ptr = nptr;
      m_sel = nsel;
      m_busy = nbusy;
      for (int i = 0; i < 4; i++) begin
        m_val[i] = nv[i];
        m_age[i] = na[i];
      end
      n_vec++; if (grant_valid !== m_busy) begin n_err++; $display("FAIL rnd_gv@%0d: got %b expected %b", cyc, grant_valid, m_busy); end
      n_vec++; if (sel !== 2'(m_sel)) begin n_err++; $display("FAIL rnd_sel@%0d: got %0d expected %0d", cyc, sel, m_sel); end
      n_vec++; if (req_ready !== ~m_full) begin n_err++; $display("FAIL rnd_ready@%0d: got %b expected %b", cyc, req_ready, ~m_full); end
      n_vec++; if ({D, C, B, A} !== {m_val[3], m_val[2], m_val[1], m_val[0]}) begin n_err++; $display("FAIL rnd_hold@%0d: got %h expected %h", cyc, {D, C, B, A}, {m_val[3], m_val[2], m_val[1], m_val[0]}); end
      if (m_busy) begin
        n_vec++; if (mux_out !== m_val[m_sel]) begin n_err++; $display("FAIL rnd_out@%0d: got %h expected %h", cyc, mux_out, m_val[m_sel]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_wrap();
    test_backpressure();
    test_reset_mid_grant();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
